// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 matrix keypad scanner with whole-scan debounce
// Revision       : 1.0
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int RUN_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [RUN_W-1:0] c_run_max  = RUN_W'(DEBOUNCE_SCANS);

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_s;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col;
  logic [1:0]       r_hits;
  logic [3:0]       r_code;
  logic [4:0]       r_prev;
  logic [RUN_W-1:0] r_run;
  logic [4:0]       r_acc;
  logic [3:0]       r_key;
  logic             r_key_valid;
  logic             r_key_held;

  logic             w_sample;
  logic             w_last_col;
  logic [3:0]       w_row_low;
  logic [2:0]       w_col_cnt;
  logic [1:0]       w_col_hits;
  logic [1:0]       w_row_sel;
  logic [2:0]       w_hits_sum;
  logic [1:0]       w_hits_next;
  logic [3:0]       w_code_next;
  logic [4:0]       w_result;
  logic [RUN_W-1:0] w_run_next;
  logic             w_accept;

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: decode = 4'h1;  4'h1: decode = 4'h2;  4'h2: decode = 4'h3;  4'h3: decode = 4'hA;
      4'h4: decode = 4'h4;  4'h5: decode = 4'h5;  4'h6: decode = 4'h6;  4'h7: decode = 4'hB;
      4'h8: decode = 4'h7;  4'h9: decode = 4'h8;  4'hA: decode = 4'h9;  4'hB: decode = 4'hC;
      4'hC: decode = 4'h0;  4'hD: decode = 4'hF;  4'hE: decode = 4'hE;  default: decode = 4'hD;
    endcase
  endfunction

  assign w_sample   = (r_cnt == c_cnt_last);
  assign w_last_col = (r_col_idx == 2'd3);
  assign w_row_low  = ~r_row_s;

  assign w_col_cnt  = {2'b00, w_row_low[0]} + {2'b00, w_row_low[1]}
                    + {2'b00, w_row_low[2]} + {2'b00, w_row_low[3]};
  assign w_col_hits = (w_col_cnt >= 3'd2) ? 2'd2 : w_col_cnt[1:0];
  assign w_row_sel  = w_row_low[0] ? 2'd0 : w_row_low[1] ? 2'd1 : w_row_low[2] ? 2'd2 : 2'd3;

  // Hit count saturates at 2: any multi-key or ghosted pattern collapses to NONE.
  assign w_hits_sum  = {1'b0, r_hits} + {1'b0, w_col_hits};
  assign w_hits_next = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
  assign w_code_next = (r_hits == 2'd0 && w_col_hits == 2'd1) ? decode(w_row_sel, r_col_idx) : r_code;
  assign w_result    = (w_hits_next == 2'd1) ? {1'b1, w_code_next} : 5'b0_0000;

  assign w_run_next = (w_result != r_prev) ? RUN_W'(1) :
                      (r_run == c_run_max) ? r_run : r_run + RUN_W'(1);
  assign w_accept   = (w_run_next == c_run_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_meta  <= 4'hF;
      r_row_s     <= 4'hF;
      r_cnt       <= '0;
      r_col_idx   <= 2'd0;
      r_col       <= 4'b1110;
      r_hits      <= 2'd0;
      r_code      <= 4'h0;
      r_prev      <= 5'b0_0000;
      r_run       <= '0;
      r_acc       <= 5'b0_0000;
      r_key       <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_row_meta  <= row;
      r_row_s     <= r_row_meta;
      r_key_valid <= 1'b0;
      if (w_sample) begin
        r_cnt     <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        r_col     <= ~(4'b0001 << (r_col_idx + 2'd1));
        if (w_last_col) begin
          r_hits <= 2'd0;
          r_code <= 4'h0;
          r_prev <= w_result;
          r_run  <= w_run_next;
          if (w_accept) begin
            r_acc      <= w_result;
            r_key_held <= w_result[4];
            if (w_result[4] && (w_result != r_acc)) begin
              r_key       <= w_result[3:0];
              r_key_valid <= 1'b1;
            end
          end
        end else begin
          r_hits <= w_hits_next;
          r_code <= w_code_next;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign col       = r_col;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : directed bench with a keypad model driving the rows
// Revision          : 1.0
// ============================================================================
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  int          checks;
  int          errors;
  int          pulses;
  int          held_low;

  typedef struct {
    logic [15:0] mask;
    int          scans;
    int          exp_pulses;
    logic [3:0]  exp_key;
    logic        exp_held;
    logic        steady;
  } vec_t;

  vec_t vq[$];
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'h0, 4'hF, 4'hE, 4'hD};

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r is pulled low when its pressed key sits in the currently driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = 1'b1;
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (key_valid) pulses++;
    if (!key_held) held_low++;
  endtask

  function automatic vec_t mk(input logic [15:0] m, input int s, input int p,
                              input logic [3:0] k, input logic h, input logic st);
    vec_t v;
    v.mask = m; v.scans = s; v.exp_pulses = p; v.exp_key = k; v.exp_held = h; v.steady = st;
    return v;
  endfunction

  initial begin
    int          first_pulse;
    logic [3:0]  pkey;
    logic        pheld;
    logic [3:0]  exp_col;

    checks = 0; errors = 0; pulses = 0; held_low = 0;
    pressed = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'hE);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);

    // Hold "5" from reset release.
    pressed = 16'h0020;
    rst_n = 1'b1;
    check("col_t0", col, 4'hE);
    first_pulse = -1; pkey = 4'h0; pheld = 1'b0; pulses = 0;
    for (int t = 1; t <= 192; t++) begin
      tick();
      if (t <= 16) begin
        exp_col = ~(4'b0001 << ((t / 4) % 4));
        check($sformatf("col_t%0d", t), col, exp_col);
      end
      if (key_valid && first_pulse < 0) begin
        first_pulse = t; pkey = key; pheld = key_held;
      end
    end
    check("press5_pulse_time", first_pulse, 32);
    check("press5_pulse_count", pulses, 1);
    check("press5_key", pkey, 4'h5);
    check("press5_held_at_pulse", pheld, 1'b1);
    check("press5_held_end", key_held, 1'b1);

    // Asynchronous reset in the middle of column 1.
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_col", col, 4'hE);
    check("mrst_key", key, 4'h0);
    check("mrst_valid", key_valid, 1'b0);
    check("mrst_held", key_held, 1'b0);
    pressed = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("mrst_col_t3", col, 4'hE);
    tick();
    check("mrst_col_t4", col, 4'hD);
    repeat (12) tick();

    vq.push_back(mk(16'h0000, 2, 0, 4'h0, 1'b0, 1'b0));
    vq.push_back(mk(16'h0020, 3, 1, 4'h5, 1'b1, 1'b0));
    vq.push_back(mk(16'h0000, 1, 0, 4'h5, 1'b1, 1'b0));
    vq.push_back(mk(16'h0000, 1, 0, 4'h5, 1'b0, 1'b0));
    vq.push_back(mk(16'h8000, 2, 1, 4'hD, 1'b1, 1'b0));
    vq.push_back(mk(16'h0000, 2, 0, 4'hD, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      vq.push_back(mk(16'h0008, 1, 0, 4'hD, 1'b0, 1'b0));
      vq.push_back(mk(16'h0000, 1, 0, 4'hD, 1'b0, 1'b0));
    end
    vq.push_back(mk(16'h0008, 2, 1, 4'hA, 1'b1, 1'b0));
    vq.push_back(mk(16'h0000, 2, 0, 4'hA, 1'b0, 1'b0));
    vq.push_back(mk(16'h0401, 3, 0, 4'hA, 1'b0, 1'b0));
    vq.push_back(mk(16'h0001, 2, 1, 4'h1, 1'b1, 1'b0));
    vq.push_back(mk(16'h0000, 2, 0, 4'h1, 1'b0, 1'b0));
    vq.push_back(mk(16'h0011, 2, 0, 4'h1, 1'b0, 1'b0));
    vq.push_back(mk(16'h0004, 2, 1, 4'h3, 1'b1, 1'b0));
    vq.push_back(mk(16'h1000, 2, 1, 4'h0, 1'b1, 1'b1));
    vq.push_back(mk(16'h0000, 2, 0, 4'h0, 1'b0, 1'b0));
    for (int i = 0; i < 16; i++) begin
      vq.push_back(mk(16'h0001 << i, 2, 1, kmap[i], 1'b1, 1'b0));
      vq.push_back(mk(16'h0000, 2, 0, kmap[i], 1'b0, 1'b0));
    end

    foreach (vq[i]) begin
      pressed = vq[i].mask;
      pulses = 0;
      held_low = 0;
      repeat (vq[i].scans * 16) tick();
      check($sformatf("vec%0d_pulses", i), pulses, vq[i].exp_pulses);
      check($sformatf("vec%0d_key", i), key, vq[i].exp_key);
      check($sformatf("vec%0d_held", i), key_held, vq[i].exp_held);
      if (vq[i].steady) check($sformatf("vec%0d_held_steady", i), held_low, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
